// File: rtl/icache_assoc.sv
// Set-associative, read-only instruction cache with per-set round-robin replacement,
// in-order multi-word block refill, whole-cache flush and hit/miss counters.
module icache_assoc #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned WOFF_W = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 30 - WOFF_W - IDX_W;
  localparam int unsigned CNT_W  = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                          state_q, state_d;
  logic [SETS-1:0][WAYS-1:0]       valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0]      rr_q, rr_d;
  logic [TAG_W-1:0]                lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0]                lat_idx_q, lat_idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [WAY_W-1:0]                victim_q, victim_d;
  logic                            vict_rr_q, vict_rr_d;
  logic [31:0]                     hit_count_q, hit_count_d;
  logic [31:0]                     miss_count_q, miss_count_d;

  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [31:0]      data_mem [SETS][WAYS][BLOCK_WORDS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [CNT_W-1:0] req_woff;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vict_way;
  logic             vict_rr;
  logic             inv_found;
  logic             start_miss;
  logic             word_wr;
  logic             last_word;
  logic [1:0]       unused_byte;

  assign req_idx     = imemaddr[IDX_W+WOFF_W+1 -: IDX_W];
  assign req_tag     = imemaddr[31 -: TAG_W];
  assign req_woff    = CNT_W'((imemaddr >> 2) & 32'(BLOCK_WORDS - 1));
  assign unused_byte = imemaddr[1:0];

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Prefer the lowest invalid way; only fall back to the rr pointer when the set is full.
  always_comb begin
    inv_found = 1'b0;
    vict_way  = rr_q[req_idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        vict_way  = WAY_W'(w);
      end
    end
    vict_rr = !inv_found;
  end

  assign ihit       = imemREN && (state_q == IDLE) && hit_any;
  assign start_miss = (state_q == IDLE) && imemREN && !ihit && !flush;
  assign word_wr    = (state_q == FETCH) && !iwait && !flush;
  assign last_word  = word_wr && (cnt_q == CNT_W'(BLOCK_WORDS - 1));

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_miss) state_d = FETCH;
      FETCH:   if (flush || last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imemload = ihit ? data_mem[req_idx][hit_way][req_woff] : '0;
    iREN     = (state_q == FETCH);
    iaddr    = '0;
    if (state_q == FETCH)
      iaddr = (32'({lat_tag_q, lat_idx_q}) << (WOFF_W + 2)) | (32'(cnt_q) << 2);
  end

  always_comb begin
    valid_d      = valid_q;
    rr_d         = rr_q;
    lat_tag_d    = lat_tag_q;
    lat_idx_d    = lat_idx_q;
    cnt_d        = cnt_q;
    victim_d     = victim_q;
    vict_rr_d    = vict_rr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (ihit) hit_count_d = hit_count_q + 32'd1;
    if (start_miss) begin
      lat_tag_d    = req_tag;
      lat_idx_d    = req_idx;
      cnt_d        = '0;
      victim_d     = vict_way;
      vict_rr_d    = vict_rr;
      miss_count_d = miss_count_q + 32'd1;
    end
    if (word_wr) cnt_d = cnt_q + CNT_W'(1);
    if (last_word) begin
      valid_d[lat_idx_q][victim_q] = 1'b1;
      if (vict_rr_q)
        rr_d[lat_idx_q] = (rr_q[lat_idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[lat_idx_q] + WAY_W'(1);
    end
    if (flush) begin
      valid_d = '0;
      rr_d    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q      <= '0;
      rr_q         <= '0;
      lat_tag_q    <= '0;
      lat_idx_q    <= '0;
      cnt_q        <= '0;
      victim_q     <= '0;
      vict_rr_q    <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      lat_tag_q    <= lat_tag_d;
      lat_idx_q    <= lat_idx_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      vict_rr_q    <= vict_rr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (word_wr)   data_mem[lat_idx_q][victim_q][cnt_q] <= iload;
    if (last_word) tag_mem[lat_idx_q][victim_q]          <= lat_tag_q;
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
